// File: rtl/dec_scan_n.sv
// dec_scan_n: N-to-2^N one-hot decoder with registered output, enable and an
// auto-scan mode that steps the shown code every DWELL clocks.
// Typical use: digit strobes for 7-segment displays or LED matrix row selects.
// DWELL must lie in 1..2^24.
module dec_scan_n #(
   parameter int SEL_W      = 3,
   parameter int DWELL      = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   output logic [(2**SEL_W)-1:0]   out,
   output logic [SEL_W-1:0]        idx,
   output logic                    wrap
);

   localparam int OUT_W = 2 ** SEL_W;
   localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [OUT_W-1:0] INACT      = {OUT_W{ACTIVE_LOW}};

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_MAN  = 2'd1,
      ST_SCAN = 2'd2
   } state_t;

   state_t          state;
   logic [DW_W-1:0] dwell;

   // Active-level select pattern for a code; polarity is folded in here so the
   // output register holds the final pin levels.
   function automatic logic [OUT_W-1:0] act_code(input logic [SEL_W-1:0] code);
      logic [OUT_W-1:0] hot;
      hot = OUT_W'(1) << code;
      return ACTIVE_LOW ? ~hot : hot;
   endfunction

   // State, dwell timer and all outputs advance together on each rising edge.
   // NOTE: every register here uses <= so all of them see the pre-edge values
   // of idx/dwell/state; a blocking = would let later lines see updated values.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and covers every register, so no output
      // ever leaves reset in an unknown state.
      if (rst) begin
         state <= ST_OFF;
         out   <= INACT;
         idx   <= '0;
         wrap  <= 1'b0;
         dwell <= '0;
      end else if (!en) begin
         // Lines released; idx keeps the last code shown.
         state <= ST_OFF;
         out   <= INACT;
         wrap  <= 1'b0;
         dwell <= '0;
      end else if (!mode) begin
         // Manual: show sel one cycle later; any scan position is dropped.
         state <= ST_MAN;
         idx   <= sel;
         out   <= act_code(sel);
         wrap  <= 1'b0;
         dwell <= '0;
      end else if (state != ST_SCAN) begin
         // Scan entry: sel is the start code and this is dwell cycle 0.
         state <= ST_SCAN;
         idx   <= sel;
         out   <= act_code(sel);
         wrap  <= 1'b0;
         dwell <= '0;
      end else if (dwell == DWELL_LAST) begin
         // Dwell period over: step to the next code, flag the top-to-zero step.
         dwell <= '0;
         idx   <= idx + 1'b1;
         out   <= act_code(idx + 1'b1);
         wrap  <= (idx == {SEL_W{1'b1}});
      end else begin
         dwell <= dwell + 1'b1;
         wrap  <= 1'b0;
      end
   end

endmodule
